// File: rtl/mp_adder_pkg.sv
// mp_adder_pkg
// Shared definitions for the sequential multi-precision adder:
//   - stateT      : FSM state encoding (IDLE, RUN, DONE)
//   - numChunks() : number of CHUNK_WIDTH slices in an ADDER_WIDTH operand
//   - idxWidth()  : bit width of the chunk index register
package mp_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    function automatic int numChunks(input int adderWidth, input int chunkWidth);
        return adderWidth / chunkWidth;
    endfunction

    // A single-chunk adder still needs a one-bit index register.
    function automatic int idxWidth(input int nChunks);
        return (nChunks > 1) ? $clog2(nChunks) : 1;
    endfunction

endpackage

// File: rtl/mp_adder_chunk.sv
// mp_adder_chunk
// Combinational CHUNK_WIDTH-bit adder slice with carry-in and carry-out.
// Ports:
//   a, b     : chunk operands (b already conditioned for subtraction)
//   carryIn  : carry into the slice
//   sum      : low CHUNK_WIDTH bits of a + b + carryIn
//   carryOut : carry out of the slice
module mp_adder_chunk #(
    parameter int CHUNK_WIDTH = 64
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   carryIn,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   carryOut
);

    always_comb begin
        {carryOut, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, carryIn};
    end

endmodule

// File: rtl/mp_adder_seq.sv
// mp_adder_seq
// Sequential multi-precision adder/subtractor. Processes one CHUNK_WIDTH
// slice per clock, least significant slice first, rippling the carry
// through a register between cycles.
// Ports:
//   iClk      : clock, rising edge
//   iRst      : synchronous active-low reset
//   iStart    : start request, accepted only while oReady is high
//   oReady    : high in IDLE
//   iA, iB    : ADDER_WIDTH operands, sampled on acceptance only
//   iC        : carry-in (add) / borrow-in (subtract)
//   iSub      : 0 = A + B + C, 1 = A - B - C
//   oSum      : registered result
//   oCarryOut : registered final carry (subtract: 1 = no borrow)
//   oDone     : one-cycle pulse when oSum/oCarryOut are final
//   oBusy     : high in RUN and DONE
module mp_adder_seq
    import mp_adder_pkg::*;
#(
    parameter int ADDER_WIDTH = 512,
    parameter int CHUNK_WIDTH = 64
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    output logic                   oReady,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iC,
    input  logic                   iSub,
    output logic [ADDER_WIDTH-1:0] oSum,
    output logic                   oCarryOut,
    output logic                   oDone,
    output logic                   oBusy
);

    localparam int NUM_CHUNKS = numChunks(ADDER_WIDTH, CHUNK_WIDTH);
    localparam int IDX_W      = idxWidth(NUM_CHUNKS);
    localparam int OFF_W      = (ADDER_WIDTH > 1) ? $clog2(ADDER_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if ((CHUNK_WIDTH <= 0) || (ADDER_WIDTH < CHUNK_WIDTH) ||
        (ADDER_WIDTH % CHUNK_WIDTH != 0)) begin : gWidthCheck
        $error("mp_adder_seq: ADDER_WIDTH must be a positive multiple of CHUNK_WIDTH");
    end

    stateT                  state;
    logic [IDX_W-1:0]       chunkIdx;
    logic                   carry;
    logic [ADDER_WIDTH-1:0] aReg;
    logic [ADDER_WIDTH-1:0] bReg;
    logic [CHUNK_WIDTH-1:0] chunkSum;
    logic                   chunkCarry;
    logic [OFF_W-1:0]       sumOff;

    // Operands are shifted down one chunk per RUN cycle, so the adder always
    // reads bit 0 upward and no wide operand mux sits in front of it.
    mp_adder_chunk #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) uChunk (
        .a        (aReg[CHUNK_WIDTH-1:0]),
        .b        (bReg[CHUNK_WIDTH-1:0]),
        .carryIn  (carry),
        .sum      (chunkSum),
        .carryOut (chunkCarry)
    );

    // Bit offset of the result chunk being written this cycle.
    always_comb begin
        sumOff = OFF_W'(chunkIdx) * OFF_W'(CHUNK_WIDTH);
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state     <= IDLE;
            chunkIdx  <= '0;
            carry     <= 1'b0;
            aReg      <= '0;
            bReg      <= '0;
            oSum      <= '0;
            oCarryOut <= 1'b0;
            oDone     <= 1'b0;
            oBusy     <= 1'b0;
            oReady    <= 1'b1;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        // Subtraction as A + ~B + (1 ^ borrow): B is inverted
                        // at capture so the RUN path is the adder alone.
                        aReg     <= iA;
                        bReg     <= iSub ? ~iB : iB;
                        carry    <= iC ^ iSub;
                        chunkIdx <= '0;
                        state    <= RUN;
                        oReady   <= 1'b0;
                        oBusy    <= 1'b1;
                    end
                end
                RUN: begin
                    oSum[sumOff +: CHUNK_WIDTH] <= chunkSum;
                    carry <= chunkCarry;
                    aReg  <= aReg >> CHUNK_WIDTH;
                    bReg  <= bReg >> CHUNK_WIDTH;
                    if (chunkIdx == LAST_IDX) begin
                        chunkIdx  <= '0;
                        oCarryOut <= chunkCarry;
                        oDone     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        chunkIdx <= chunkIdx + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    oBusy  <= 1'b0;
                    oReady <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    chunkIdx <= '0;
                    oBusy    <= 1'b0;
                    oReady   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_adder_seq.sv
module tb_mp_adder_seq;

    localparam int AW = 128;
    localparam int CW = 32;
    localparam int NC = AW / CW;

    logic          iClk   = 1'b0;
    logic          iRst   = 1'b0;
    logic          iStart = 1'b0;
    logic [AW-1:0] iA     = '0;
    logic [AW-1:0] iB     = '0;
    logic          iC     = 1'b0;
    logic          iSub   = 1'b0;
    logic          oReady;
    logic [AW-1:0] oSum;
    logic          oCarryOut;
    logic          oDone;
    logic          oBusy;

    mp_adder_seq #(
        .ADDER_WIDTH(AW),
        .CHUNK_WIDTH(CW)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .oReady    (oReady),
        .iA        (iA),
        .iB        (iB),
        .iC        (iC),
        .iSub      (iSub),
        .oSum      (oSum),
        .oCarryOut (oCarryOut),
        .oDone     (oDone),
        .oBusy     (oBusy)
    );

    typedef struct {
        logic [AW-1:0] sum;
        logic          cout;
        int            doneCyc;
    } expT;

    expT sbq[$];
    int  checks   = 0;
    int  errors   = 0;
    int  cyc      = 0;
    int  doneSeen = 0;

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    // Reference: plain wide arithmetic on whole operands.
    function automatic expT model(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                  input logic c, input logic sub, input int dc);
        expT         r;
        logic [AW:0] full;
        if (!sub) begin
            full   = {1'b0, a} + {1'b0, b} + {{AW{1'b0}}, c};
            r.sum  = full[AW-1:0];
            r.cout = full[AW];
        end else begin
            r.sum  = a - b - {{(AW-1){1'b0}}, c};
            r.cout = ({1'b0, a} >= ({1'b0, b} + {{AW{1'b0}}, c}));
        end
        r.doneCyc = dc;
        return r;
    endfunction

    task automatic check(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rword();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [AW-1:0] rop();
        return {rword(), rword(), rword(), rword()};
    endfunction

    // Scoreboard monitor: compares each oDone against the oldest expectation.
    always @(negedge iClk) begin
        expT e;
        if (oDone) begin
            doneSeen++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpectedDone: got oDone=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sbq.pop_front();
                check("sum", oSum, e.sum);
                check("carryOut", AW'(oCarryOut), AW'(e.cout));
                check("latency", AW'(cyc), AW'(e.doneCyc));
                check("busyAtDone", AW'(oBusy), AW'(1));
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].doneCyc) begin
            checks++;
            errors++;
            $display("FAIL missingDone: got no oDone by cycle %0d expected at %0d", cyc, sbq[0].doneCyc);
            e = sbq.pop_front();
        end
    end

    // Drive one start request; pushes an expectation only if it will be accepted.
    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic c, input logic sub, output bit acc);
        @(negedge iClk);
        iA = a; iB = b; iC = c; iSub = sub; iStart = 1'b1;
        acc = oReady && iRst;
        if (acc) sbq.push_back(model(a, b, c, sub, cyc + NC + 1));
        @(negedge iClk);
        iStart = 1'b0;
        iA = rop(); iB = rop(); iC = 1'($urandom); iSub = 1'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!oReady && n < 20) begin
            @(negedge iClk);
            n++;
        end
        if (!oReady) check("idleTimeout", AW'(oReady), AW'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge iClk);
            n++;
        end
        if (sbq.size() > 0) check("drainTimeout", AW'(sbq.size()), AW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            acc;
        int            accCyc[$];
        int            d0;
        logic [AW-1:0] ones;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          c;
        logic          s;
        ones = '1;

        // Reset state
        repeat (3) @(negedge iClk);
        check("rstReady", AW'(oReady), AW'(1));
        check("rstBusy", AW'(oBusy), AW'(0));
        check("rstDone", AW'(oDone), AW'(0));
        check("rstSum", oSum, '0);
        check("rstCarry", AW'(oCarryOut), AW'(0));
        iRst = 1'b1;

        // All-ones + 0 + carry-in wraps to zero with carry out
        issue(ones, '0, 1'b1, 1'b0, acc);
        waitIdle();
        check("wrapSum", oSum, '0);
        check("wrapCarry", AW'(oCarryOut), AW'(1));

        // 0 - 1 borrows; 5 - 3 - 1 = 1 without borrow
        issue('0, AW'(1), 1'b0, 1'b1, acc);
        waitIdle();
        check("borrowSum", oSum, ones);
        check("borrowCarry", AW'(oCarryOut), AW'(0));
        issue(AW'(5), AW'(3), 1'b1, 1'b1, acc);
        waitIdle();
        check("subSum", oSum, AW'(1));
        check("subCarry", AW'(oCarryOut), AW'(1));

        // Start during RUN with different operands is ignored
        d0 = doneSeen;
        issue(AW'(100), AW'(23), 1'b0, 1'b0, acc);
        issue(ones, ones, 1'b1, 1'b0, acc);
        check("ignoredStart", AW'(acc), AW'(0));
        waitIdle();
        drain();
        check("ignoredSum", oSum, AW'(123));
        check("oneDone", AW'(doneSeen - d0), AW'(1));

        // Reset in the second RUN cycle aborts with no done pulse
        d0 = doneSeen;
        @(negedge iClk);
        iA = rop(); iB = rop(); iC = 1'b1; iSub = 1'b0; iStart = 1'b1;
        if (oReady) sbq.push_back(model(iA, iB, iC, iSub, cyc + NC + 1));
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        sbq.delete();
        @(negedge iClk);
        check("abortReady", AW'(oReady), AW'(1));
        check("abortBusy", AW'(oBusy), AW'(0));
        check("abortSum", oSum, '0);
        check("abortDone", AW'(oDone), AW'(0));
        iRst = 1'b1;
        repeat (8) @(negedge iClk);
        check("abortNoDone", AW'(doneSeen - d0), AW'(0));

        // iStart held high for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            iA = rop(); iB = rop(); iC = 1'($urandom); iSub = 1'($urandom);
            iStart = 1'b1;
            if (oReady && iRst) begin
                sbq.push_back(model(iA, iB, iC, iSub, cyc + NC + 1));
                accCyc.push_back(cyc);
            end
        end
        @(negedge iClk);
        iStart = 1'b0;
        check("heldAccepts", AW'(accCyc.size()), AW'(4));
        for (int i = 1; i < accCyc.size(); i++)
            check("heldSpacing", AW'(accCyc[i] - accCyc[i-1]), AW'(NC + 2));
        waitIdle();
        drain();

        // Chunk-boundary carry
        issue(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, AW'(1), 1'b0, 1'b0, acc);
        waitIdle();
        check("boundarySum", oSum, 128'h00000001_00000000_00000000_00000000);
        check("boundaryCarry", AW'(oCarryOut), AW'(0));

        // Random operations
        for (int i = 0; i < 1000; i++) begin
            a = rop(); b = rop(); c = 1'($urandom); s = 1'($urandom);
            issue(a, b, c, s, acc);
            if (!acc) check("randAccept", AW'(acc), AW'(1));
            if ($urandom_range(0, 3) == 0) @(negedge iClk);
            waitIdle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mp_adder_seq.md
MP_ADDER_SEQ -- requirements
Module: mp_adder_seq

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 512: total operand width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 64: bits added per cycle; ADDER_WIDTH SHALL be an integer multiple of CHUNK_WIDTH, else elaboration error.
REQ-003 SHALL have one clock and a synchronous, active-low reset; the ports are named iClk and iRst.
REQ-004 SHALL have port iClk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port iRst  in  1  synchronous active-low reset.
REQ-006 SHALL have port iStart  in  1  request to begin an operation.
REQ-007 SHALL have port oReady  out  1  high when a start is accepted (state IDLE).
REQ-008 SHALL have port iA  in  ADDER_WIDTH  operand A.
REQ-009 SHALL have port iB  in  ADDER_WIDTH  operand B.
REQ-010 SHALL have port iC  in  1  carry-in (add) / borrow-in (subtract).
REQ-011 SHALL have port iSub  in  1  0 = add, 1 = subtract.
REQ-012 SHALL have port oSum  out  ADDER_WIDTH  registered result.
REQ-013 SHALL have port oCarryOut  out  1  registered final carry (subtract: 1 = no borrow).
REQ-014 SHALL have port oDone  out  1  one-cycle pulse when oSum/oCarryOut are valid.
REQ-015 SHALL have port oBusy  out  1  high in states RUN and DONE.

Function
REQ-016 SHALL define NUM_CHUNKS = ADDER_WIDTH/CHUNK_WIDTH; chunk k = bits [k*CHUNK_WIDTH +: CHUNK_WIDTH], k = 0 is least significant.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; IDLE -> RUN on iStart & oReady; RUN -> DONE after chunk NUM_CHUNKS-1; DONE -> IDLE unconditionally.
REQ-018 SHALL on acceptance capture iA, iB, iSub; set internal carry = iC XOR iSub; clear the chunk index to 0.
REQ-019 SHALL in each RUN cycle with index k compute A_k + (iSub ? ~B_k : B_k) + carry; write the low CHUNK_WIDTH bits to oSum chunk k; store the chunk carry-out as the next carry; increment k.
REQ-020 SHALL be exact modulo 2^ADDER_WIDTH: add gives A+B+iC; subtract gives A-B-iC; oCarryOut = carry out of chunk NUM_CHUNKS-1.
REQ-021 SHALL have fixed latency: start accepted in cycle T -> RUN in cycles T+1..T+NUM_CHUNKS -> oDone=1 only in cycle T+NUM_CHUNKS+1.
REQ-022 SHALL make oSum and oCarryOut final and stable in the oDone cycle; they SHALL hold until the first RUN cycle of the next operation.
REQ-023 SHALL ignore iStart outside IDLE; a start that is not accepted SHALL NOT be queued.
REQ-024 SHALL accept iStart held high continuously every NUM_CHUNKS+2 cycles.
REQ-025 SHALL NOT require iA/iB/iC/iSub to be stable after the acceptance cycle.
REQ-026 SHALL wrap the chunk index only via the RUN -> DONE transition; the index SHALL never exceed NUM_CHUNKS-1.

Reset
REQ-027 SHALL, when iRst=0 at a rising edge, force state IDLE, chunk index 0, carry 0, oSum=0, oCarryOut=0, oDone=0, oBusy=0, oReady=1 (after that edge).
REQ-028 SHALL abort any operation in progress on reset, with no oDone pulse; reset SHALL take priority over iStart in the same cycle.

Structure
REQ-029 SHALL place the FSM state enum, the NUM_CHUNKS computation and a clog2-based index width in shared package mp_adder_pkg.
REQ-030 SHALL instantiate one combinational sub-module, mp_adder_chunk (CHUNK_WIDTH parameter; inputs A, B, carry-in; outputs sum, carry-out), for the per-cycle addition.
REQ-031 SHALL keep every operand, carry and result bit in registers (register-to-register paths only) so that timing closes on the chunk adder alone.

Verification (ADDER_WIDTH=128, CHUNK_WIDTH=32)
REQ-032 SHALL test: A=2^128-1, B=0, iC=1, iSub=0, accepted in cycle T -> oDone in T+5, oSum=0, oCarryOut=1.
REQ-033 SHALL test: A=0, B=1, iC=0, iSub=1 -> oSum=2^128-1, oCarryOut=0 (borrow); then A=5, B=3, iC=1, iSub=1 -> oSum=1, oCarryOut=1.
REQ-034 SHALL test: iStart pulsed in a RUN cycle with different operands -> ignored; the result equals the first operation; exactly one oDone.
REQ-035 SHALL test: iRst=0 in the second RUN cycle -> next cycle oReady=1, oBusy=0, oSum=0, and no oDone pulse.
REQ-036 SHALL test: iStart held high for 20 cycles -> acceptances 6 cycles apart, each result correct against a reference model.
REQ-037 SHALL test: 1000 random operations against a reference model, including chunk-boundary carries (A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 -> oSum=0x00000001_00000000_00000000_00000000, oCarryOut=0).
